a2d_sequencer: RTL and testbench

Round-robin conversion sequencer that sits directly upstream of the SPI A2D interface and drives its `strt_cnv`/`chnnl`/`cnv_cmplt` handshake. It sweeps channels 0..NUM_CH-1 and takes 2^LOG2_AVG conversions per channel. It averages each channel's conversions into a per-channel result register, then waits out a fixed sweep period before starting the next sweep. Control logic reads averaged sensor values through a registered read port and uses the sweep/valid flags to know when data is fresh.

---
 rtl/a2d_sequencer.sv | 177 +++++++++++++++++
 tb/tb_a2d_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/a2d_sequencer.sv
// a2d_sequencer: round-robin A2D conversion sequencer.
// Sweeps channels 0..NUM_CH-1, averages 2^LOG2_AVG conversions per channel
// into a result register, then waits out the sweep period before the next
// sweep. Results are read through a registered read port.
module a2d_sequencer #(
  parameter int NUM_CH   = 8,
  parameter int LOG2_AVG = 2,
  parameter int PERIOD   = 4096,
  parameter int TIMEOUT  = 8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  input  logic [2:0]  rd_ch,
  output logic [11:0] rd_data,
  output logic        busy,
  output logic        sweep_done,
  output logic        data_vld,
  output logic        to_err
);

  localparam int ACC_W  = 12 + LOG2_AVG;
  localparam int SAMP_W = 5;
  localparam int PER_W  = $clog2(PERIOD);
  localparam int TO_W   = $clog2(TIMEOUT);

  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'((1 << LOG2_AVG) - 1);
  localparam logic [2:0]        LAST_CH   = 3'(NUM_CH - 1);
  localparam logic [3:0]        NUM_CH_L  = 4'(NUM_CH);
  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, CONV, PWAIT} state_t;

  state_t              state_q;
  logic [2:0]          ch_q;
  logic [SAMP_W-1:0]   samp_q;
  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    acc_d;
  logic [PER_W-1:0]    per_q;
  logic [TO_W-1:0]     to_q;
  logic [11:0]         avg_q [8];
  logic                strt_q;
  logic [2:0]          chnnl_q;
  logic [11:0]         rd_q;
  logic                busy_q;
  logic                sd_q;
  logic                vld_q;
  logic                err_q;

  // Truncating average: drop the LOG2_AVG fraction bits of the sum.
  function automatic logic [11:0] avg_trunc(input logic [ACC_W-1:0] sum);
    return sum[ACC_W-1 -: 12];
  endfunction

  // Running sum including the sample being captured this cycle.
  always_comb begin
    acc_d = acc_q + ACC_W'(res);
  end

  // Sequencer FSM with registered handshake, status and read-port outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ch_q    <= '0;
      samp_q  <= '0;
      acc_q   <= '0;
      per_q   <= '0;
      to_q    <= '0;
      strt_q  <= 1'b0;
      chnnl_q <= '0;
      rd_q    <= '0;
      busy_q  <= 1'b0;
      sd_q    <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < 8; i++) avg_q[i] <= '0;
    end else begin
      strt_q <= 1'b0;
      sd_q   <= 1'b0;

      // Registered read; a same-cycle write is seen one cycle later.
      rd_q <= ({1'b0, rd_ch} < NUM_CH_L) ? avg_q[rd_ch] : '0;

      // Sweep period counter saturates so a long sweep leaves one PWAIT cycle.
      if (state_q != IDLE && per_q != PER_LAST) per_q <= per_q + PER_W'(1);

      case (state_q)
        IDLE: begin
          if (en) begin
            state_q <= START;
            ch_q    <= '0;
            samp_q  <= '0;
            acc_q   <= '0;
            per_q   <= '0;
            strt_q  <= 1'b1;
            chnnl_q <= '0;
            busy_q  <= 1'b1;
          end
        end

        START: begin
          to_q    <= '0;
          state_q <= CONV;
        end

        CONV: begin
          to_q <= to_q + TO_W'(1);
          if (cnv_cmplt) begin
            if (samp_q == SAMP_LAST) begin
              avg_q[ch_q] <= avg_trunc(acc_d);
              acc_q       <= '0;
              samp_q      <= '0;
              if (ch_q == LAST_CH) begin
                sd_q    <= 1'b1;
                vld_q   <= 1'b1;
                state_q <= PWAIT;
              end else begin
                ch_q    <= ch_q + 3'd1;
                chnnl_q <= ch_q + 3'd1;
                strt_q  <= 1'b1;
                state_q <= START;
              end
            end else begin
              acc_q   <= acc_d;
              samp_q  <= samp_q + SAMP_W'(1);
              chnnl_q <= ch_q;
              strt_q  <= 1'b1;
              state_q <= START;
            end
          end else if (to_q == TO_LAST) begin
            // Give up on this conversion and retry the same sample.
            err_q   <= 1'b1;
            chnnl_q <= ch_q;
            strt_q  <= 1'b1;
            state_q <= START;
          end
        end

        PWAIT: begin
          if (per_q == PER_LAST) begin
            if (en) begin
              state_q <= START;
              ch_q    <= '0;
              samp_q  <= '0;
              acc_q   <= '0;
              per_q   <= '0;
              strt_q  <= 1'b1;
              chnnl_q <= '0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign strt_cnv   = strt_q;
  assign chnnl      = chnnl_q;
  assign rd_data    = rd_q;
  assign busy       = busy_q;
  assign sweep_done = sd_q;
  assign data_vld   = vld_q;
  assign to_err     = err_q;

endmodule

// File: tb/tb_a2d_sequencer.sv
// Directed bench for a2d_sequencer with a behavioural A2D model.
// DUT: NUM_CH=2, LOG2_AVG=2, PERIOD=64, TIMEOUT=32.
module tb_a2d_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic [2:0]  rd_ch;
  logic [11:0] rd_data;
  logic        busy;
  logic        sweep_done;
  logic        data_vld;
  logic        to_err;

  int checks = 0;
  int errors = 0;

  // A2D model controls
  int lat   = 2;
  bit hang  = 1'b0;
  int base0 = 100;
  int val1  = 4095;
  int rem   = 0;
  int idx0  = 0;
  logic [2:0] cur_ch = '0;

  // Event log
  int cyc = 0;
  int nstart = 0;
  int sd_cnt = 0;
  int sd_t = 0;
  bit new_sweep = 1'b1;
  int st_t[$];
  int sweep_t[$];
  logic [2:0] ch_log[$];

  a2d_sequencer #(
    .NUM_CH(2), .LOG2_AVG(2), .PERIOD(64), .TIMEOUT(32)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .strt_cnv(strt_cnv), .chnnl(chnnl),
    .cnv_cmplt(cnv_cmplt), .res(res),
    .rd_ch(rd_ch), .rd_data(rd_data),
    .busy(busy), .sweep_done(sweep_done),
    .data_vld(data_vld), .to_err(to_err)
  );

  always #5 clk = ~clk;

  // A2D model: goes low after a start pulse, stays low for lat CONV cycles,
  // then returns high with the next result for the latched channel.
  always @(negedge clk) begin
    if (strt_cnv) begin
      cnv_cmplt = 1'b0;
      rem       = hang ? 1000 : lat;
      hang      = 1'b0;
      cur_ch    = chnnl;
    end else if (!cnv_cmplt) begin
      if (rem == 0) begin
        cnv_cmplt = 1'b1;
        res       = (cur_ch == 3'd0) ? 12'(base0 + idx0) : 12'(val1);
        if (cur_ch == 3'd0) idx0 = (idx0 + 1) % 4;
      end else begin
        rem = rem - 1;
      end
    end
  end

  // Cycle-stamped log of start pulses and sweep completions.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (strt_cnv) begin
      st_t.push_back(cyc);
      ch_log.push_back(chnnl);
      if (new_sweep) sweep_t.push_back(cyc);
      new_sweep = 1'b0;
      nstart = nstart + 1;
    end
    if (sweep_done) begin
      sd_cnt = sd_cnt + 1;
      sd_t = cyc;
      new_sweep = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_sd(input int n);
    for (int i = 0; i < 400 && sd_cnt < n; i++) @(negedge clk);
    chk("wait_sweep_done", 32'(sd_cnt >= n), 32'd1);
  endtask

  task automatic wait_sweeps(input int n);
    for (int i = 0; i < 400 && sweep_t.size() < n; i++) @(negedge clk);
    chk("wait_sweep_start", 32'(sweep_t.size() >= n), 32'd1);
  endtask

  task automatic wait_strt(input logic [2:0] ch);
    for (int i = 0; i < 200 && !(strt_cnv && chnnl == ch); i++) @(negedge clk);
    chk("wait_strt", 32'(strt_cnv && chnnl == ch), 32'd1);
  endtask

  task automatic read_ch(input logic [2:0] ch, input string tag, input int exp);
    rd_ch = ch;
    repeat (2) @(negedge clk);
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_strt_cnv"},   32'(strt_cnv),   32'd0);
    chk({pfx, "_chnnl"},      32'(chnnl),      32'd0);
    chk({pfx, "_rd_data"},    32'(rd_data),    32'd0);
    chk({pfx, "_busy"},       32'(busy),       32'd0);
    chk({pfx, "_sweep_done"}, 32'(sweep_done), 32'd0);
    chk({pfx, "_data_vld"},   32'(data_vld),   32'd0);
    chk({pfx, "_to_err"},     32'(to_err),     32'd0);
  endtask

  initial begin
    logic [7:0] chseq;
    int n_before;

    cnv_cmplt = 1'b1;
    res   = '0;
    rst   = 1'b1;
    en    = 1'b0;
    rd_ch = 3'd0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_strt", 32'(nstart), 32'd0);

    // First sweep: ch0 = 100..103, ch1 = 4095 x4
    en = 1'b1;
    @(negedge clk);
    chk("first_strt", 32'(strt_cnv), 32'd1);
    chk("first_busy", 32'(busy), 32'd1);
    chk("first_chnnl", 32'(chnnl), 32'd0);

    wait_sd(1);
    chk("sweep1_sd_pulse_width", 32'(sweep_done), 32'd0);
    chk("sweep1_sd_count", 32'(sd_cnt), 32'd1);
    chk("sweep1_data_vld", 32'(data_vld), 32'd1);
    chk("sweep1_busy_pwait", 32'(busy), 32'd1);
    chk("sweep1_nstart", 32'(nstart), 32'd8);
    chseq = '0;
    for (int i = 0; i < 8 && i < ch_log.size(); i++) chseq[i] = ch_log[i][0];
    chk("sweep1_chnnl_seq", 32'(chseq), 32'hF0);

    base0 = 200;
    val1  = 50;
    read_ch(3'd0, "rd_reg0", 101);
    read_ch(3'd1, "rd_reg1", 4095);
    read_ch(3'd7, "rd_out_of_range", 0);
    rd_ch = 3'd0;

    // Second sweep: exact period, en dropped during ch0, read-during-write
    wait_sweeps(2);
    if (sweep_t.size() >= 2)
      chk("period_spacing", 32'(sweep_t[1] - sweep_t[0]), 32'd64);
    en = 1'b0;
    wait_strt(3'd1);
    chk("rdw_old_value", 32'(rd_data), 32'd101);
    @(negedge clk);
    chk("rdw_new_value", 32'(rd_data), 32'd201);
    wait_sd(2);
    repeat (80) @(negedge clk);
    chk("en_off_busy", 32'(busy), 32'd0);
    chk("en_off_nstart", 32'(nstart), 32'd16);
    chk("en_off_sd_count", 32'(sd_cnt), 32'd2);
    read_ch(3'd1, "rd_reg1_sweep2", 50);

    // Timeout sweep: first ch0 conversion never completes
    base0 = 40;
    hang  = 1'b1;
    en    = 1'b1;
    wait_strt(3'd0);
    en = 1'b0;
    for (int i = 0; i < 100 && !to_err; i++) @(negedge clk);
    chk("to_err_set", 32'(to_err), 32'd1);
    wait_sd(3);
    if (st_t.size() >= 18)
      chk("timeout_retry_gap", 32'(st_t[17] - st_t[16]), 32'd33);
    chk("timeout_nstart", 32'(nstart), 32'd25);
    read_ch(3'd0, "timeout_avg", 41);
    chk("to_err_sticky", 32'(to_err), 32'd1);
    repeat (80) @(negedge clk);

    // Long sweep (> PERIOD), then reset mid-CONV of the next sweep
    lat   = 10;
    base0 = 100;
    val1  = 4095;
    en    = 1'b1;
    wait_sd(4);
    wait_sweeps(5);
    if (sweep_t.size() >= 5)
      chk("long_sweep_restart", 32'(sweep_t[4] - sd_t), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    rd_ch = 3'd0;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("midconv_rst");
    n_before = nstart;
    repeat (30) @(negedge clk);
    chk("post_rst_no_strt", 32'(nstart), 32'(n_before));
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_no_capture", 32'(rd_data), 32'd0);
    chk("post_rst_data_vld", 32'(data_vld), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
